// File: rtl/adf4360_pkg.sv
// rtl/adf4360_pkg.sv - shared ADF4360 address map, sequence states and word width
package adf4360_pkg;

  localparam int WORD_WIDTH = 24;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_R      = 2'b01;
  localparam logic [1:0] ADDR_N      = 2'b10;
  localparam logic [1:0] ADDR_UNUSED = 2'b11;

  typedef enum logic [1:0] {
    SEQ_R    = 2'd0,
    SEQ_C    = 2'd1,
    SEQ_N    = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adf4360_spi_rx_sync_edge.sv
// rtl/adf4360_spi_rx_sync_edge.sv - multi-flop synchronizer with rise/fall pulses
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   hist;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stages <= '0;
      hist   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      hist   <= stages[SYNC_STAGES-1];
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/adf4360_spi_rx.sv
// rtl/adf4360_spi_rx.sv - ADF4360 3-wire write receiver with shadow registers
// and power-up sequence checker
module adf4360_spi_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter int          WORD_WIDTH  = 24,
  parameter logic [15:0] MIN_GAP_CYC = 16'd20
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sclk_i,
  input  logic                  sdata_i,
  input  logic                  le_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [1:0]            addr_o,
  output logic                  word_valid_o,
  output logic [WORD_WIDTH-1:0] r_reg_o,
  output logic [WORD_WIDTH-1:0] c_reg_o,
  output logic [WORD_WIDTH-1:0] n_reg_o,
  output logic                  frame_err_o,
  output logic                  seq_err_o,
  output logic                  seq_done_o
);
  import adf4360_pkg::*;

  localparam logic [4:0] FULL_CNT = 5'(WORD_WIDTH);

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic le_level, le_rise, le_fall_unused;
  logic sdata_s, sdata_rise_unused, sdata_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_i), .reset_i(reset_i), .din(sclk_i),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk_i(clk_i), .reset_i(reset_i), .din(le_i),
    .level(le_level), .rise(le_rise), .fall(le_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk_i(clk_i), .reset_i(reset_i), .din(sdata_i),
    .level(sdata_s), .rise(sdata_rise_unused), .fall(sdata_fall_unused)
  );

  logic [WORD_WIDTH-1:0] shift, shift_nxt, lat_word;
  logic [4:0]            bit_cnt, cnt_nxt;
  logic                  shift_en, lat_ok, lat_err;
  seq_state_t            seq;
  logic [15:0]           gap;

  // An sclk rise coincident with the le rise still shifts: le was low a cycle ago.
  assign shift_en  = sclk_rise & (~le_level | le_rise);
  assign shift_nxt = shift_en ? {shift[WORD_WIDTH-2:0], sdata_s} : shift;
  assign cnt_nxt   = shift_en ? ((bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1) : bit_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift    <= '0;
      bit_cnt  <= '0;
      lat_word <= '0;
      lat_ok   <= 1'b0;
      lat_err  <= 1'b0;
    end else begin
      shift   <= shift_nxt;
      bit_cnt <= cnt_nxt;
      lat_ok  <= 1'b0;
      lat_err <= 1'b0;
      if (le_rise) begin
        bit_cnt <= '0;
        if (cnt_nxt == FULL_CNT) begin
          lat_ok   <= 1'b1;
          lat_word <= shift_nxt;
        end else begin
          lat_err <= 1'b1;
        end
      end
    end
  end

  // Output stage: word, shadows and sequence checker all update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_o       <= '0;
      addr_o       <= '0;
      word_valid_o <= 1'b0;
      r_reg_o      <= '0;
      c_reg_o      <= '0;
      n_reg_o      <= '0;
      frame_err_o  <= 1'b0;
      seq_err_o    <= 1'b0;
      seq_done_o   <= 1'b0;
      seq          <= SEQ_R;
      gap          <= '0;
    end else begin
      word_valid_o <= lat_ok;
      frame_err_o  <= lat_err;
      seq_err_o    <= 1'b0;
      if (seq == SEQ_N) gap <= sat_inc16(gap);
      if (lat_ok) begin
        word_o <= lat_word;
        addr_o <= lat_word[1:0];
        case (lat_word[1:0])
          ADDR_R: begin
            r_reg_o <= lat_word;
            if (seq != SEQ_DONE) seq <= SEQ_C;
          end
          ADDR_CTRL: begin
            c_reg_o <= lat_word;
            case (seq)
              SEQ_R:        seq_err_o <= 1'b1;
              SEQ_C, SEQ_N: begin
                seq <= SEQ_N;
                gap <= '0;
              end
              default: ;
            endcase
          end
          ADDR_N: begin
            n_reg_o <= lat_word;
            case (seq)
              SEQ_R: seq_err_o <= 1'b1;
              SEQ_C: begin
                seq_err_o <= 1'b1;
                seq       <= SEQ_R;
              end
              SEQ_N: begin
                // gap holds cycles since the C latch minus one; count this cycle too.
                if (sat_inc16(gap) >= MIN_GAP_CYC) begin
                  seq        <= SEQ_DONE;
                  seq_done_o <= 1'b1;
                end else begin
                  seq_err_o <= 1'b1;
                  seq       <= SEQ_R;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
